// File: rtl/alu_pkg.sv
// alu_share_arb shared types: ALU opcodes, arbiter states, default width.
// Imported by alu_share_arb and rr_pick.
package alu_pkg;

  localparam int DW_DEF = 8;

  typedef enum logic [2:0] {
    AND = 3'b000,
    ADD = 3'b001,
    XOR = 3'b010,
    BNE = 3'b011,
    LS  = 3'b100,
    RS  = 3'b101,
    LW  = 3'b110,
    STR = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_share_arb_rr_pick.sv
// rr_pick: combinational round-robin picker; first set bit of i_req
// at or above i_ptr (wrapping). Ports: i_req, i_ptr -> o_gnt, o_idx, o_any.
module rr_pick
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  localparam logic [IW:0] NR = (IW+1)'(NREQ);

  logic [IW:0] w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_j >= NR)
        w_j = w_j - NR;
      if (!o_any && i_req[w_j[IW-1:0]]) begin
        o_any              = 1'b1;
        o_gnt[w_j[IW-1:0]] = 1'b1;
        o_idx              = w_j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin share of one combinational ALU among NREQ
// requesters. Ports: req_* (valid/ready op in), alu_* (to/from ALU),
// rsp_* (valid/ready result out), busy. Macro ALU_ARB_BACK2BACK_EN lets
// RESP grant the next op directly (2-cycle spacing instead of 3).
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = DW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [3*NREQ-1:0] req_cmd,
  input  logic [DW*NREQ-1:0] req_a,
  input  logic [DW*NREQ-1:0] req_b,
  input  logic [DW*NREQ-1:0] req_c,
  output logic [2:0]        alu_cmd,
  output logic [DW-1:0]     alu_a,
  output logic [DW-1:0]     alu_b,
  output logic [DW-1:0]     alu_c,
  input  logic [DW-1:0]     alu_rslt,
  input  logic              alu_branch,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [DW-1:0]     rsp_rslt,
  output logic              rsp_branch,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e      r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_owner;
  alu_op_e         r_cmd;
  logic [DW-1:0]   r_a;
  logic [DW-1:0]   r_b;
  logic [DW-1:0]   r_c;
  logic [DW-1:0]   r_rslt;
  logic            r_branch;

  logic [IW-1:0]   w_ptr_sel;
  logic [IW-1:0]   w_nxt_ptr;
  logic [NREQ-1:0] w_gnt;
  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic            w_hs;
  logic            w_take;

  assign w_nxt_ptr = (r_owner == IW'(NREQ-1)) ? '0 : r_owner + 1'b1;
  assign w_hs      = (r_state == RESP) && rsp_ready[r_owner];

`ifdef ALU_ARB_BACK2BACK_EN
  // Completing handshake doubles as an IDLE cycle with the advanced pointer.
  assign w_ptr_sel = (r_state == RESP) ? w_nxt_ptr : r_ptr;
  assign w_take    = w_any && ((r_state == IDLE) || w_hs);
`else
  assign w_ptr_sel = r_ptr;
  assign w_take    = w_any && (r_state == IDLE);
`endif

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .i_req (req_valid),
    .i_ptr (w_ptr_sel),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign req_ready  = w_take ? w_gnt : '0;
  assign alu_cmd    = r_cmd;
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_c      = r_c;
  assign rsp_rslt   = r_rslt;
  assign rsp_branch = r_branch;
  assign busy       = (r_state != IDLE);

  always_comb begin
    rsp_valid = '0;
    if (r_state == RESP)
      rsp_valid[r_owner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_owner  <= '0;
      r_cmd    <= AND;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_rslt   <= '0;
      r_branch <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_take)
            r_state <= EXEC;
        end
        EXEC: begin
          r_rslt   <= alu_rslt;
          r_branch <= alu_branch;
          r_state  <= RESP;
        end
        RESP: begin
          if (w_hs) begin
            r_ptr   <= w_nxt_ptr;
            r_state <= w_take ? EXEC : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_take) begin
        r_owner <= w_idx;
        r_cmd   <= alu_op_e'(req_cmd[3*w_idx +: 3]);
        r_a     <= req_a[DW*w_idx +: DW];
        r_b     <= req_b[DW*w_idx +: DW];
        r_c     <= req_c[DW*w_idx +: DW];
      end
    end
  end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Round-robin arbiter and sequencer that shares the single combinational ALU among NREQ requesters, for example the core datapath and the address/loop unit.
- Each requester issues an ALU op over a valid/ready handshake.
- The block latches operands, drives the ALU for one cycle, and registers the result and branch flag.
- It returns the response to the owning requester over a valid/ready handshake.

Parameters:
- NREQ, 2, number of requesters (2..4).
- DW, 8, ALU data width.

Ports:
- clk  in  1  clock (one clock only).
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester op request.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_cmd  in  3*NREQ  packed alu_op_e per requester.
- req_a  in  DW*NREQ  packed operand A.
- req_b  in  DW*NREQ  packed operand B.
- req_c  in  DW*NREQ  packed operand C (branch target for BNE).
- alu_cmd  out  3  to ALU command input.
- alu_a  out  DW  to ALU inA.
- alu_b  out  DW  to ALU inB.
- alu_c  out  DW  to ALU inC.
- alu_rslt  in  DW  from ALU result.
- alu_branch  in  1  from ALU branch_pc.
- rsp_valid  out  NREQ  per-requester response valid; one-hot or zero.
- rsp_ready  in  NREQ  per-requester response accept.
- rsp_rslt  out  DW  registered result, shared bus.
- rsp_branch  out  1  registered branch flag.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, rst_n low): state IDLE; rr_ptr=0; owner=0; operand regs, rsp_rslt, rsp_branch all 0; req_ready=0; rsp_valid=0; busy=0. ALU outputs therefore drive cmd=AND, operands 0.
- ALU outputs always come from the operand registers, never combinationally from req_*.
- IDLE:
  - If no req_valid, stay in IDLE.
  - Otherwise pick the first requester with req_valid set, searching from rr_ptr upward with wrap (NREQ-1 -> 0).
  - Assert req_ready for that requester only, in the same cycle (combinational from req_valid and rr_ptr).
  - At the clock edge, latch cmd/a/b/c and owner, then go to EXEC.
- EXEC (1 cycle): ALU sees the latched operands. At the edge, register alu_rslt into rsp_rslt and alu_branch into rsp_branch, then go to RESP.
- RESP:
  - rsp_valid[owner]=1; rsp_rslt and rsp_branch are held stable.
  - When rsp_ready[owner] is high: rsp_valid drops the next cycle, rr_ptr <= owner+1 (mod NREQ), state goes to IDLE.
  - rsp_ready of non-owners is ignored.
- Latency: accept at cycle t, rsp_valid at t+2. Without the optional feature, minimum spacing is 3 cycles per op.
- Requester rules:
  - Requesters hold req_* stable while valid and not ready.
  - A requester may drop req_valid before it is granted; it is then simply not selected.
- Fairness: a continuously requesting requester waits at most NREQ-1 ops.
- Result rules:
  - For BNE with inA==inB, rsp_rslt=0 and rsp_branch=0.
  - The block passes through unmodified all 8 codes, including LW/STR (inA).
- Reset mid-operation: the in-flight op is discarded, no response is produced, and rr_ptr returns to 0.
- req_ready is never asserted outside IDLE, except as described under the optional feature.

Optional Feature:
- Macro: ALU_ARB_BACK2BACK_EN.
- Defined:
  - In RESP, in the cycle rsp_ready[owner] completes the handshake, the arbiter also performs the IDLE selection.
  - The search uses the post-update pointer (owner+1).
  - If a request is granted, it asserts req_ready, latches it, and goes directly to EXEC, skipping IDLE.
  - Spacing becomes 2 cycles per op.
- Undefined: the behaviour described under Behaviour applies (always returns through IDLE).

Decomposition:
- Package alu_pkg:
  - alu_op_e enum: AND=3'b000, ADD=001, XOR=010, BNE=011, LS=100, RS=101, LW=110, STR=111.
  - Localparam DW_DEF=8.
  - arb_state_e enum: IDLE, EXEC, RESP.
- Sub-module rr_pick (combinational): inputs req vector and ptr; outputs one-hot grant and grant index. Used by IDLE and by the back-to-back path.

Test Plan:
- Single op: req0 ADD a=3 b=4 → req_ready[0] in cycle 0; rsp_valid[0] at cycle 2 with rsp_rslt=7, rsp_branch=0; busy high for cycles 1..2.
- BNE: req1 cmd=011 a=5 b=6 c=8'h2A → rsp_rslt=8'h2A, rsp_branch=1. Repeat with a=b=5 → rsp_rslt=0, rsp_branch=0.
- Contention: both requesters valid continuously from reset, req0 XOR(0xF0,0xFF), req1 LS(a=2,b=1) → grant order 0,1,0,1; responses 0x0F and 0x04 alternate; never two grants in one op.
- Response stall: hold rsp_ready[0]=0 for 5 cycles → rsp_valid[0], rsp_rslt and rsp_branch stay stable; req_ready stays 0 for the pending req1; after the stall, req1 is granted.
- Reset mid-op: assert rst_n low during EXEC → all outputs 0 asynchronously; no rsp_valid after release; the next op is granted to req0 first.
- Back-to-back (macro defined): both requesters continuous, rsp_ready tied high → grants every 2 cycles, alternating 0,1; with the macro undefined, grants come every 3 cycles.
